rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Power-domain style clock/reset sequencer: brings N domains up one at a time
// (clock enable first, then reset release) and tears them down in reverse order.
module rst_seq_ctrl #(
  parameter int N_DOMAINS   = 4,
  parameter int DLY_W       = 8,
  parameter int CLK_EN_LEAD = 2
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RI,
  input  logic                         Start_SI,
  input  logic                         Stop_SI,
  input  logic [N_DOMAINS*DLY_W-1:0]   Dly_DI,
  output logic [N_DOMAINS-1:0]         ClkEn_SO,
  output logic [N_DOMAINS-1:0]         Rst_RBO,
  output logic                         Busy_SO,
  output logic                         Up_SO,
  output logic                         Done_SO
);

  localparam int LW = $clog2(CLK_EN_LEAD + 1);
  localparam int CW = (DLY_W > LW) ? DLY_W : LW;
  localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [CW-1:0] LEAD_RELOAD = CW'(CLK_EN_LEAD - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    IDLE, EN_CLK, REL_RST, SETTLE, UP, ASSERT_RST, GATE_CLK
  } state_e;

  state_e                     state_q;
  logic [IW-1:0]              idx_q;
  logic [CW-1:0]              cnt_q;
  logic [N_DOMAINS*DLY_W-1:0] dly_q;
  logic [DLY_W-1:0]           dly_arr [N_DOMAINS];

  for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_dly
    assign dly_arr[gi] = dly_q[gi*DLY_W +: DLY_W];
  end

  always_ff @(posedge Clk_CI) begin
    Done_SO <= 1'b0;
    if (Rst_RI) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      dly_q    <= '0;
      ClkEn_SO <= '0;
      Rst_RBO  <= '0;
      Busy_SO  <= 1'b0;
      Up_SO    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start_SI && !Stop_SI) begin
            dly_q   <= Dly_DI;
            idx_q   <= '0;
            Busy_SO <= 1'b1;
            state_q <= EN_CLK;
          end
        end
        EN_CLK: begin
          if (Stop_SI) begin
            state_q <= ASSERT_RST;
          end else begin
            ClkEn_SO[idx_q] <= 1'b1;
            cnt_q           <= LEAD_RELOAD;
            state_q         <= REL_RST;
          end
        end
        REL_RST: begin
          if (Stop_SI) begin
            state_q <= ASSERT_RST;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            Rst_RBO[idx_q] <= 1'b1;
            cnt_q          <= CW'(dly_arr[idx_q]);
            state_q        <= SETTLE;
          end
        end
        SETTLE: begin
          if (Stop_SI) begin
            state_q <= ASSERT_RST;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (idx_q == LAST_IDX) begin
            Up_SO   <= 1'b1;
            Busy_SO <= 1'b0;
            state_q <= UP;
          end else begin
            // Next domain's clock starts here, so its lead count begins now.
            ClkEn_SO[idx_q + IW'(1)] <= 1'b1;
            idx_q                    <= idx_q + IW'(1);
            cnt_q                    <= LEAD_RELOAD;
            state_q                  <= REL_RST;
          end
        end
        UP: begin
          if (Stop_SI) state_q <= ASSERT_RST;
        end
        ASSERT_RST: begin
          Rst_RBO[idx_q] <= 1'b0;
          Up_SO          <= 1'b0;
          Busy_SO        <= 1'b1;
          cnt_q          <= LEAD_RELOAD;
          state_q        <= GATE_CLK;
        end
        GATE_CLK: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (idx_q != '0) begin
            ClkEn_SO[idx_q] <= 1'b0;
            idx_q           <= idx_q - IW'(1);
            state_q         <= ASSERT_RST;
          end else if (ClkEn_SO[0]) begin
            // Domain 0 gated now; completion is reported one cycle later.
            ClkEn_SO[0] <= 1'b0;
          end else begin
            Busy_SO <= 1'b0;
            Done_SO <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl (N=4, LEAD=2): bring-up, teardown, abort,
// zero delay, mid-sequence reset and ignored requests.
module tb_rst_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [31:0] dly;
  logic [3:0]  clken, rstb;
  logic        busy, up, done;
  int          total = 0;
  int          bad   = 0;

  rst_seq_ctrl #(.N_DOMAINS(4), .DLY_W(8), .CLK_EN_LEAD(2)) dut (
    .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .Stop_SI(stop), .Dly_DI(dly),
    .ClkEn_SO(clken), .Rst_RBO(rstb), .Busy_SO(busy), .Up_SO(up), .Done_SO(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int k, input logic [3:0] ce, input logic [3:0] rb,
                         input logic b, input logic u, input logic d);
    $display("%s k=%0d clken=%b rstb=%b busy=%b up=%b done=%b", tag, k, clken, rstb, busy, up, done);
    chk({tag, ".clken"}, k, clken, ce);
    chk({tag, ".rstb"},  k, rstb,  rb);
    chk({tag, ".busy"},  k, {3'b0, busy}, {3'b0, b});
    chk({tag, ".up"},    k, {3'b0, up},   {3'b0, u});
    chk({tag, ".done"},  k, {3'b0, done}, {3'b0, d});
  endtask

  // Expected outputs k edges after Start was sampled (edge 0), settle delay d:
  // domain i clock at 1+i*(d+3), reset release 2 later, Up at 1+4*(d+3).
  task automatic bu_check(input string tag, input int k, input int d);
    logic [3:0] ce, rb;
    int p;
    p = d + 3;
    for (int i = 0; i < 4; i++) begin
      ce[i] = (k >= 1 + i*p);
      rb[i] = (k >= 3 + i*p);
    end
    chk_all(tag, k, ce, rb, (k < 1 + 4*p), (k >= 1 + 4*p), 1'b0);
  endtask

  // Expected outputs j edges after Stop was sampled in UP.
  task automatic td_check(input string tag, input int j);
    logic [3:0] ce, rb;
    for (int i = 0; i < 4; i++) begin
      rb[i] = (j < 1 + 3*(3-i));
      ce[i] = (j < 3 + 3*(3-i));
    end
    chk_all(tag, j, ce, rb, (j < 13), 1'b0, (j == 13));
  endtask

  task automatic teardown(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      td_check(tag, j);
      if (j == 5) start = 1'b1;
      if (j == 6) start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; dly = 32'h03030303;
    tick(); tick(); tick();
    chk_all("reset", 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Start in the first cycle after reset release; Dly changes while busy are ignored.
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; dly = 32'h01010101;
    for (int k = 1; k <= 25; k++) begin
      tick();
      bu_check("bringup_d3", k, 3);
    end
    tick(); tick();
    chk_all("up_hold", 27, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);

    teardown("teardown_d3");

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    chk_all("idle_start_stop", 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk_all("idle_stop", 0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    dly = 32'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      bu_check("bringup_d0", k, 0);
    end
    teardown("teardown_d0");

    // Abort: Rst_RBO[1] rises at edge 9, Stop sampled at edge 11.
    dly = 32'h03030303;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) stop = 1'b1;
      tick();
      stop = 1'b0;
      if (k <= 11) bu_check("abort", k, 3);
      else chk_all("abort", k, {2'b00, (k < 14), (k < 17)}, {2'b00, 1'b0, (k < 15)},
                   (k < 18), 1'b0, (k == 18));
    end

    // Reset while domain 0 is settling, then an identical fresh bring-up.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bu_check("pre_reset", k, 3);
    end
    rst = 1'b1;
    tick();
    chk_all("mid_reset", 6, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      bu_check("rebringup", k, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
